// File: rtl/transmissor_estado_jogo_pkg.sv
// rtl/transmissor_estado_jogo_pkg.sv - shared constants, state codes and ASCII helpers for the game-state transmitter
package pkg_jogo;

  localparam int FRAME_LEN = 28;
  localparam int MAP_LEN   = 16;

  localparam logic [7:0] ASCII_M   = 8'h4D;
  localparam logic [7:0] ASCII_H   = 8'h48;
  localparam logic [7:0] ASCII_V   = 8'h56;
  localparam logic [7:0] ASCII_L   = 8'h4C;
  localparam logic [7:0] ASCII_C   = 8'h43;
  localparam logic [7:0] ASCII_D   = 8'h44;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_A10 = 8'h37;

  typedef enum logic [3:0] {
    E_IDLE      = 4'd0,
    E_CAPTURA   = 4'd1,
    E_LE_MAPA   = 4'd2,
    E_CARREGA   = 4'd3,
    E_TRANSMITE = 4'd4,
    E_FIM       = 4'd5
  } estado_t;

  typedef struct packed {
    logic [3:0] horiz;
    logic [1:0] vert;
    logic [2:0] vidas;
    logic [2:0] colisoes;
    logic [1:0] modo;
  } snapshot_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A10 + {4'h0, n});
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] n);
    return ASCII_0 + {4'h0, n};
  endfunction

endpackage

// File: rtl/transmissor_estado_jogo_uart.sv
// rtl/transmissor_estado_jogo_uart.sv - UART 8N1 byte transmitter with start pulse and done pulse
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dado,
  output logic       saida,
  output logic       pronto
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);

  logic          busy_q, busy_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    dado_q, dado_d;
  logic          saida_q, saida_d;
  logic          fim_bit;

  // The stop bit ends one cycle early: the caller's reload cycle keeps the
  // line high and completes it, so back-to-back bytes have no idle gap.
  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    dado_d  = dado_q;
    saida_d = saida_q;
    pronto  = 1'b0;
    fim_bit = (bit_q == 4'd9) ? (baud_q == STOP_LAST) : (baud_q == BAUD_LAST);
    if (!busy_q) begin
      saida_d = 1'b1;
      if (partida) begin
        busy_d  = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        dado_d  = dado;
        saida_d = 1'b0;
      end
    end else if (fim_bit) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        pronto = 1'b1;
      end else begin
        bit_d   = 4'(bit_q + 4'd1);
        saida_d = (bit_q <= 4'd7) ? dado_q[bit_q[2:0]] : 1'b1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      dado_q  <= '0;
      saida_q <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      dado_q  <= dado_d;
      saida_q <= saida_d;
    end
  end

  assign saida = saida_q;

endmodule

// File: rtl/transmissor_estado_jogo.sv
// rtl/transmissor_estado_jogo.sv - snapshots game state and map RAM, sends one ASCII frame over UART
module transmissor_estado_jogo
  import pkg_jogo::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [3:0] posicao_horiz,
  input  logic [1:0] posicao_vert,
  input  logic [2:0] vidas,
  input  logic [2:0] colisoes,
  input  logic [1:0] modo,
  output logic [3:0] map_addr,
  input  logic [3:0] map_data,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t    state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] addr_q, addr_d;
  snapshot_t  snap_q, snap_d;
  logic [3:0] mapa_q [MAP_LEN];
  logic [3:0] mapa_d [MAP_LEN];

  logic       partida;
  logic       uart_pronto;
  logic [7:0] byte_sel;
  logic [3:0] wr_idx;
  logic [3:0] map_idx;

  assign wr_idx  = 4'(cnt_q - 5'd1);
  assign map_idx = 4'(idx_q - 5'd1);

  // LE_MAPA: cnt_q counts 0..16; address k is issued at cnt=k and its data
  // arrives at cnt=k+1, so the sweep takes 17 cycles.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    snap_d  = snap_q;
    mapa_d  = mapa_q;
    partida = 1'b0;
    case (state_q)
      E_IDLE: begin
        if (envia) state_d = E_CAPTURA;
      end
      E_CAPTURA: begin
        snap_d.horiz    = posicao_horiz;
        snap_d.vert     = posicao_vert;
        snap_d.vidas    = vidas;
        snap_d.colisoes = colisoes;
        snap_d.modo     = modo;
        addr_d  = 4'd0;
        cnt_d   = 5'd0;
        idx_d   = 5'd0;
        state_d = E_LE_MAPA;
      end
      E_LE_MAPA: begin
        if (cnt_q != 5'd0) mapa_d[wr_idx] = map_data;
        if (cnt_q < 5'd15) addr_d = addr_q + 4'd1;
        if (cnt_q == 5'd16) state_d = E_CARREGA;
        else cnt_d = cnt_q + 5'd1;
      end
      E_CARREGA: begin
        partida = 1'b1;
        state_d = E_TRANSMITE;
      end
      E_TRANSMITE: begin
        if (uart_pronto) begin
          if (idx_q < 5'(FRAME_LEN - 1)) begin
            idx_d   = idx_q + 5'd1;
            state_d = E_CARREGA;
          end else begin
            state_d = E_FIM;
          end
        end
      end
      E_FIM: state_d = E_IDLE;
      default: state_d = E_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = ASCII_LF;
    if (idx_q == 5'd0) begin
      byte_sel = ASCII_M;
    end else if (idx_q <= 5'd16) begin
      byte_sel = hex_ascii(mapa_q[map_idx]);
    end else begin
      case (idx_q)
        5'd17:   byte_sel = ASCII_H;
        5'd18:   byte_sel = hex_ascii(snap_q.horiz);
        5'd19:   byte_sel = ASCII_V;
        5'd20:   byte_sel = digit_ascii({2'b00, snap_q.vert});
        5'd21:   byte_sel = ASCII_L;
        5'd22:   byte_sel = digit_ascii({1'b0, snap_q.vidas});
        5'd23:   byte_sel = ASCII_C;
        5'd24:   byte_sel = digit_ascii({1'b0, snap_q.colisoes});
        5'd25:   byte_sel = ASCII_D;
        5'd26:   byte_sel = digit_ascii({2'b00, snap_q.modo});
        default: byte_sel = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= E_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      snap_q  <= '0;
      for (int k = 0; k < MAP_LEN; k++) mapa_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      snap_q  <= snap_d;
      mapa_q  <= mapa_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock  (clock),
    .reset  (reset),
    .partida(partida),
    .dado   (byte_sel),
    .saida  (saida_serial),
    .pronto (uart_pronto)
  );

  assign map_addr  = addr_q;
  assign ocupado   = (state_q != E_IDLE);
  assign pronto    = (state_q == E_FIM);
  assign db_estado = state_q;

endmodule

// File: tb/tb_transmissor_estado_jogo.sv
// tb/tb_transmissor_estado_jogo.sv - self-checking bench: line waveform vs string-built frame model
module tb_transmissor_estado_jogo;

  localparam int CPB   = 4;
  localparam int NBYTE = 28;
  localparam int WIN   = NBYTE * 10 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       envia;
  logic [3:0] posicao_horiz;
  logic [1:0] posicao_vert;
  logic [2:0] vidas;
  logic [2:0] colisoes;
  logic [1:0] modo;
  logic [3:0] map_addr;
  logic [3:0] map_data;
  logic       saida_serial;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] ram [16];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) map_data <= ram[map_addr];

  transmissor_estado_jogo #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .envia        (envia),
    .posicao_horiz(posicao_horiz),
    .posicao_vert (posicao_vert),
    .vidas        (vidas),
    .colisoes     (colisoes),
    .modo         (modo),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string model_frame();
    string hexd;
    string s;
    hexd = "0123456789ABCDEF";
    s = "M";
    for (int k = 0; k < 16; k++) s = $sformatf("%s%c", s, hexd[ram[k]]);
    s = $sformatf("%sH%cV%0dL%0dC%0dD%0d%c", s, hexd[posicao_horiz], posicao_vert,
                  vidas, colisoes, modo, 8'h0A);
    return s;
  endfunction

  function automatic logic line_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // action: 0 none, 1 change inputs/RAM during byte 3, 2 envia pulse during byte 10
  task automatic run_frame(input string tag, input int action, input bit pulse, input bit busy_after);
    string s;
    logic  got_bits [WIN];
    logic [39:0] got_w, exp_w;
    logic [7:0] eb;
    int n_pronto, next_addr;
    bit started, busy_ok, line_ok;
    s = model_frame();
    if (pulse) begin
      @(negedge clock); envia = 1'b1;
      @(negedge clock); envia = 1'b0;
    end
    next_addr = 0;
    started = 1'b0;
    for (int t = 0; t < 200 && !started; t++) begin
      @(negedge clock);
      if (next_addr < 16 && map_addr == 4'(next_addr)) next_addr++;
      if (saida_serial == 1'b0) started = 1'b1;
    end
    check({tag, " start"}, 64'(started), 64'd1);
    if (pulse) check({tag, " addr_sweep"}, 64'(next_addr), 64'd16);
    n_pronto = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) @(negedge clock);
      got_bits[i] = saida_serial;
      if (n_pronto == 0 && !ocupado) busy_ok = 1'b0;
      if (pronto) n_pronto++;
      if (action == 1 && i == 3*10*CPB + 10) begin
        posicao_horiz = 4'd9;
        ram[0] = 4'hF;
      end
      if (action == 2 && i == 10*10*CPB + 5) envia = 1'b1;
      if (action == 2 && i == 10*10*CPB + 7) envia = 1'b0;
    end
    for (int b = 0; b < NBYTE; b++) begin
      eb = s[b];
      for (int k = 0; k < 10*CPB; k++) begin
        got_w[39-k] = got_bits[b*10*CPB + k];
        exp_w[39-k] = line_bit(eb, k / CPB);
      end
      check($sformatf("%s byte%0d", tag, b), 64'(got_w), 64'(exp_w));
    end
    line_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (pronto) n_pronto++;
      if (!saida_serial) line_ok = 1'b0;
    end
    check({tag, " pronto_count"}, 64'(n_pronto), 64'd1);
    check({tag, " ocupado_until_pronto"}, 64'(busy_ok), 64'd1);
    check({tag, " line_idle_after"}, 64'(line_ok), 64'd1);
    check({tag, " ocupado_after"}, 64'(ocupado), 64'(busy_after));
  endtask

  task automatic randomize_state();
    for (int k = 0; k < 16; k++) ram[k] = 4'($urandom);
    posicao_horiz = 4'($urandom);
    posicao_vert  = 2'($urandom);
    vidas         = 3'($urandom_range(0, 7));
    colisoes      = 3'($urandom_range(0, 7));
    modo          = 2'($urandom);
  endtask

  initial begin
    int n_pronto;
    bit ok;
    reset = 1'b1;
    envia = 1'b0;
    posicao_horiz = '0; posicao_vert = '0; vidas = '0; colisoes = '0; modo = '0;
    for (int k = 0; k < 16; k++) ram[k] = 4'd0;

    repeat (3) @(negedge clock);
    check("rst saida", 64'(saida_serial), 64'd1);
    check("rst ocupado", 64'(ocupado), 64'd0);
    check("rst pronto", 64'(pronto), 64'd0);
    check("rst map_addr", 64'(map_addr), 64'd0);
    check("rst estado", 64'(db_estado), 64'd0);
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0) ok = 1'b0;
    end
    check("idle 100 cycles", 64'(ok), 64'd1);

    posicao_horiz = 4'd0; posicao_vert = 2'd2; vidas = 3'd3; colisoes = 3'd0; modo = 2'd1;
    run_frame("basic", 0, 1'b1, 1'b0);

    for (int k = 0; k < 16; k++) ram[k] = 4'(k);
    posicao_horiz = 4'hA; posicao_vert = 2'd3; vidas = 3'd5; colisoes = 3'd2; modo = 2'd2;
    run_frame("hexmap", 0, 1'b1, 1'b0);

    randomize_state();
    ram[0] = 4'h3;
    posicao_horiz = 4'd5;
    run_frame("snapshot", 1, 1'b1, 1'b0);

    randomize_state();
    run_frame("busy_envia", 2, 1'b1, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ocupado !== 1'b0 || saida_serial !== 1'b1) ok = 1'b0;
    end
    check("busy_envia not queued", 64'(ok), 64'd1);

    randomize_state();
    @(negedge clock); envia = 1'b1;
    @(negedge clock); envia = 1'b0;
    repeat (20 + 10*10*CPB + 10) @(negedge clock);
    check("midrst busy before", 64'(ocupado), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst saida", 64'(saida_serial), 64'd1);
    check("midrst estado", 64'(db_estado), 64'd0);
    check("midrst ocupado", 64'(ocupado), 64'd0);
    @(negedge clock);
    check("midrst saida next", 64'(saida_serial), 64'd1);
    reset = 1'b0;
    n_pronto = 0;
    ok = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clock);
      if (pronto) n_pronto++;
      if (saida_serial !== 1'b1 || ocupado !== 1'b0) ok = 1'b0;
    end
    check("midrst no pronto", 64'(n_pronto), 64'd0);
    check("midrst line idle", 64'(ok), 64'd1);

    randomize_state();
    @(negedge clock); envia = 1'b1;
    run_frame("hold1", 0, 1'b0, 1'b1);
    envia = 1'b0;
    run_frame("hold2", 0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      randomize_state();
      run_frame($sformatf("rand%0d", r), 0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
